gpio_to_mouse: RTL and testbench
================================

GPIO_TO_MOUSE -- requirements
Module: gpio_to_mouse

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 400, meaning consecutive clk cycles a changed level must persist before acceptance (10 us at 40 MHz); legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the per-channel qualification counter.
REQ-003 SHALL have port clk, input, 1, the single clock (40 MHz pixel clock domain).
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port gpio_left_in, input, 1, asynchronous remote left-button level from the peer board.
REQ-006 SHALL have port gpio_right_in, input, 1, asynchronous remote right-button level from the peer board.
REQ-007 SHALL have port m_left, output, 1, qualified remote left command.
REQ-008 SHALL have port m_right, output, 1, qualified remote right command.
REQ-009 SHALL have port left_press, output, 1, one-cycle pulse on acceptance of a left rising level.
REQ-010 SHALL have port right_press, output, 1, one-cycle pulse on acceptance of a right rising level.
REQ-011 SHALL have port conflict, output, 1, both filtered levels high.
REQ-012 SHALL have port glitch_cnt, output, 8, saturating count of rejected pulses (both channels combined).

Function
REQ-013 SHALL pass each GPIO input through a two-flop synchronizer; only the second stage (sync) feeds logic.
REQ-014 SHALL keep per channel a filtered level (filt) and a counter (cnt) of width CNT_W.
REQ-015 Per channel, each cycle: sync == filt -> cnt cleared to 0; sync != filt and cnt < STABLE_CYCLES-1 -> cnt increments; sync != filt and cnt == STABLE_CYCLES-1 -> filt takes sync, cnt cleared.
REQ-016 SHALL give pin-to-filt latency of exactly STABLE_CYCLES+2 rising edges for a level held stable from before the first sampling edge.
REQ-017 SHALL treat a pulse whose sync differs from filt for 1..STABLE_CYCLES-1 cycles and then returns as rejected: filt unchanged, glitch_cnt increments by 1 on the cycle cnt is cleared from a nonzero value by sync == filt.
REQ-018 glitch_cnt SHALL saturate at 255 and never wrap; simultaneous rejections on both channels in one cycle SHALL increment by 2 (saturating at 255).
REQ-019 m_left SHALL equal filt_left AND NOT filt_right; m_right SHALL equal filt_right AND NOT filt_left; both registered.
REQ-020 conflict SHALL equal filt_left AND filt_right, registered.
REQ-021 left_press/right_press SHALL pulse high for exactly one cycle, on the same edge filt rises 0->1; no pulse on a 1->0 transition.
REQ-022 A press pulse SHALL be generated even if the other channel's filt is high (conflict does not mask pulses).
REQ-023 Simultaneous qualification on both channels SHALL update both filts on the same edge and assert both press pulses together.
REQ-024 All outputs SHALL be registered; no combinational path from GPIO inputs to outputs.

Reset
REQ-025 rst assertion SHALL immediately clear synchronizer flops, filt, cnt, m_left, m_right, left_press, right_press, conflict and glitch_cnt to 0, regardless of clk.
REQ-026 rst asserted mid-qualification SHALL discard the partial count; after release, qualification restarts from cnt = 0.
REQ-027 After rst release with an input already high, that input SHALL be accepted after STABLE_CYCLES+2 edges and produce a press pulse.

Verification
REQ-028 STABLE_CYCLES=4: gpio_left_in 0->1 held -> m_left=1 and left_press=1 for one cycle exactly 6 edges later; m_right, conflict stay 0.
REQ-029 STABLE_CYCLES=4: gpio_right_in high for 3 cycles then low -> m_right stays 0, right_press never asserts, glitch_cnt = 1.
REQ-030 STABLE_CYCLES=4: left held high, then right raised -> after right qualifies m_left=0, m_right=0, conflict=1, right_press pulses once; drop left -> 6 edges later m_right=1, conflict=0, no pulse.
REQ-031 STABLE_CYCLES=4: 300 rejected 2-cycle glitches on left -> glitch_cnt stops at 255.
REQ-032 STABLE_CYCLES=4: both inputs raised on same edge -> both press pulses on the same edge, conflict=1, m_left=m_right=0.
REQ-033 Assert rst asynchronously between clk edges during left qualification -> all outputs 0 before next edge; input held high through release -> m_left=1 6 edges after release.

Source files
------------

// File: rtl/gpio_to_mouse.sv
// Qualifies two asynchronous remote button levels from the peer board into mouse commands.
// Each channel is synchronized, then debounced by a persistence counter; rejected pulses are tallied.
module gpio_to_mouse #(
  parameter int unsigned STABLE_CYCLES = 400,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gpio_left_in,
  input  logic       gpio_right_in,
  output logic       m_left,
  output logic       m_right,
  output logic       left_press,
  output logic       right_press,
  output logic       conflict,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  // Bit 0 is the left channel, bit 1 the right channel throughout.
  logic [1:0]       sync_1, sync_2;
  logic [1:0]       filt, filt_nx;
  logic [CNT_W-1:0] cnt    [2];
  logic [CNT_W-1:0] cnt_nx [2];
  logic [1:0]       rej;
  logic [8:0]       glitch_sum;
  logic [7:0]       glitch_nx;

  always_comb begin
    filt_nx = filt;
    rej     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_nx[i] = cnt[i];
      if (sync_2[i] == filt[i]) begin
        cnt_nx[i] = '0;
        rej[i]    = (cnt[i] != '0);
      end else if (cnt[i] == LAST) begin
        filt_nx[i] = sync_2[i];
        cnt_nx[i]  = '0;
      end else begin
        cnt_nx[i] = cnt[i] + CNT_W'(1);
      end
    end
    glitch_sum = {1'b0, glitch_cnt} + {8'b0, rej[0]} + {8'b0, rej[1]};
    glitch_nx  = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
  end

  // Outputs are registered from the next filtered levels so they change on the same edge as filt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1      <= '0;
      sync_2      <= '0;
      filt        <= '0;
      cnt[0]      <= '0;
      cnt[1]      <= '0;
      m_left      <= 1'b0;
      m_right     <= 1'b0;
      left_press  <= 1'b0;
      right_press <= 1'b0;
      conflict    <= 1'b0;
      glitch_cnt  <= '0;
    end else begin
      sync_1      <= {gpio_right_in, gpio_left_in};
      sync_2      <= sync_1;
      filt        <= filt_nx;
      cnt[0]      <= cnt_nx[0];
      cnt[1]      <= cnt_nx[1];
      m_left      <= filt_nx[0] & ~filt_nx[1];
      m_right     <= filt_nx[1] & ~filt_nx[0];
      left_press  <= filt_nx[0] & ~filt[0];
      right_press <= filt_nx[1] & ~filt[1];
      conflict    <= filt_nx[0] & filt_nx[1];
      glitch_cnt  <= glitch_nx;
    end
  end

endmodule

// File: tb/tb_gpio_to_mouse.sv
// Directed bench for gpio_to_mouse with STABLE_CYCLES=4 (acceptance 6 edges after a pin change).
module tb_gpio_to_mouse;

  logic       clk = 1'b0;
  logic       rst;
  logic       gpio_left_in, gpio_right_in;
  logic       m_left, m_right, left_press, right_press, conflict;
  logic [7:0] glitch_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int lp_seen, rp_seen;

  gpio_to_mouse #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_left_in (gpio_left_in),
    .gpio_right_in(gpio_right_in),
    .m_left       (m_left),
    .m_right      (m_right),
    .left_press   (left_press),
    .right_press  (right_press),
    .conflict     (conflict),
    .glitch_cnt   (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns after it, counting any press pulses seen.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (left_press)  lp_seen++;
      if (right_press) rp_seen++;
    end
  endtask

  task automatic do_reset;
    gpio_left_in  = 1'b0;
    gpio_right_in = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    lp_seen = 0;
    rp_seen = 0;
  endtask

  initial begin
    gpio_left_in  = 1'b0;
    gpio_right_in = 1'b0;
    lp_seen = 0;
    rp_seen = 0;
    rst = 1'b1;
    #2;
    check("rst_m_left", m_left, 0);
    check("rst_m_right", m_right, 0);
    check("rst_conflict", conflict, 0);
    check("rst_glitch", glitch_cnt, 0);
    tick(2);
    rst = 1'b0;
    lp_seen = 0;
    rp_seen = 0;

    // Left accepted exactly 6 edges after the change, one-cycle press.
    gpio_left_in = 1'b1;
    tick(5);
    check("left_edge5_m_left", m_left, 0);
    check("left_edge5_press", left_press, 0);
    tick(1);
    check("left_edge6_m_left", m_left, 1);
    check("left_edge6_press", left_press, 1);
    check("left_edge6_m_right", m_right, 0);
    check("left_edge6_conflict", conflict, 0);
    tick(1);
    check("left_edge7_press", left_press, 0);
    check("left_edge7_m_left", m_left, 1);
    gpio_left_in = 1'b0;
    tick(6);
    check("left_fall_m_left", m_left, 0);
    check("left_total_presses", lp_seen, 1);

    // Right 3-cycle glitch is rejected.
    do_reset();
    gpio_right_in = 1'b1;
    tick(3);
    gpio_right_in = 1'b0;
    tick(8);
    check("glitch3_m_right", m_right, 0);
    check("glitch3_presses", rp_seen, 0);
    check("glitch3_cnt", glitch_cnt, 1);

    // Conflict: left held, right raised, then left dropped.
    do_reset();
    gpio_left_in = 1'b1;
    tick(6);
    check("conf_m_left_first", m_left, 1);
    gpio_right_in = 1'b1;
    tick(6);
    check("conf_m_left", m_left, 0);
    check("conf_m_right", m_right, 0);
    check("conf_conflict", conflict, 1);
    check("conf_right_press", right_press, 1);
    tick(1);
    check("conf_right_press_end", right_press, 0);
    gpio_left_in = 1'b0;
    tick(5);
    check("drop_edge5_m_right", m_right, 0);
    check("drop_edge5_conflict", conflict, 1);
    tick(1);
    check("drop_m_right", m_right, 1);
    check("drop_conflict", conflict, 0);
    check("drop_left_presses", lp_seen, 1);
    check("drop_right_presses", rp_seen, 1);

    // Saturation with single-channel glitches.
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      gpio_left_in = 1'b1;
      tick(2);
      gpio_left_in = 1'b0;
      tick(4);
      if (i == 10)  check("sat_cnt_10", glitch_cnt, 10);
      if (i == 255) check("sat_cnt_255", glitch_cnt, 255);
    end
    check("sat_cnt_300", glitch_cnt, 255);
    check("sat_m_left", m_left, 0);
    check("sat_presses", lp_seen, 0);

    // Simultaneous rejections count 2 and clamp at 255 from 254.
    do_reset();
    for (int i = 1; i <= 128; i++) begin
      gpio_left_in  = 1'b1;
      gpio_right_in = 1'b1;
      tick(2);
      gpio_left_in  = 1'b0;
      gpio_right_in = 1'b0;
      tick(4);
      if (i == 1)   check("dual_cnt_1", glitch_cnt, 2);
      if (i == 127) check("dual_cnt_127", glitch_cnt, 254);
    end
    check("dual_cnt_sat", glitch_cnt, 255);

    // Both raised together.
    do_reset();
    gpio_left_in  = 1'b1;
    gpio_right_in = 1'b1;
    tick(6);
    check("both_left_press", left_press, 1);
    check("both_right_press", right_press, 1);
    check("both_conflict", conflict, 1);
    check("both_m_left", m_left, 0);
    check("both_m_right", m_right, 0);

    // Async reset mid-qualification, input held through release.
    do_reset();
    gpio_left_in = 1'b1;
    tick(5);
    gpio_right_in = 1'b1;
    tick(1);
    check("pre_rst_m_left", m_left, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_m_left", m_left, 0);
    check("async_left_press", left_press, 0);
    check("async_glitch", glitch_cnt, 0);
    gpio_right_in = 1'b0;
    tick(2);
    #2;
    rst = 1'b0;
    lp_seen = 0;
    tick(5);
    check("rel_edge5_m_left", m_left, 0);
    tick(1);
    check("rel_edge6_m_left", m_left, 1);
    check("rel_edge6_press", left_press, 1);
    check("rel_presses", lp_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
